// File: rtl/eeg_seq_pkg.sv
// Shared types and default sizes for the EEG ADC sequencer.
// FSM state encoding lives here so the sub-module and top agree.
package eeg_seq_pkg;

  localparam int SEQ_NUM_CH = 8;
  localparam int SEQ_CH_W   = $clog2(SEQ_NUM_CH);
  localparam int SEQ_DATA_W = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_EMIT
  } seq_state_e;

endpackage

// File: rtl/seq_next_ch.sv
// Finds the lowest set mask bit strictly above the current channel.
// none_o flags that no higher channel remains in the frame.
module seq_next_ch
  import eeg_seq_pkg::*;
#(
  parameter int NUM_CH = SEQ_NUM_CH,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   cur_i,
  output logic [CH_W-1:0]   nxt_o,
  output logic              none_o
);

  // Scan downward so the last hit is the lowest qualifying bit.
  always_comb begin
    nxt_o  = '0;
    none_o = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_i))) begin
        nxt_o  = CH_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/eeg_adc_sequencer.sv
// Frame-driven multiplexed ADC sequencer for EEG front ends.
// Define SEQ_TIMEOUT_EN to enable the lost-conversion timeout.
module eeg_adc_sequencer
  import eeg_seq_pkg::*;
#(
  parameter int NUM_CH      = SEQ_NUM_CH,
  parameter int DATA_W      = SEQ_DATA_W,
  parameter int FRAME_DIV   = 1000,
  parameter int TIMEOUT_CYC = 256,
  localparam int CH_W =
    (NUM_CH == SEQ_NUM_CH) ? SEQ_CH_W : $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              halt,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              adc_start,
  output logic [CH_W-1:0]   adc_ch,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              smp_valid,
  output logic [CH_W-1:0]   smp_ch,
  output logic [DATA_W-1:0] smp_data,
  output logic              frame_done,
  output logic              busy,
  output logic [7:0]        overrun_cnt,
  output logic              timeout_err
);

  localparam int CNT_W =
    (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FRAME_DIV - 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] WAIT_LAST =
    TW'(TIMEOUT_CYC - 1);

`ifdef SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  seq_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TW-1:0]     wait_q;
  logic [NUM_CH-1:0] mask_q;
  logic [CH_W-1:0]   cur_q;
  logic              start_q;
  logic              valid_q;
  logic              fdone_q;
  logic [CH_W-1:0]   sch_q;
  logic [DATA_W-1:0] sdat_q;
  logic [7:0]        ovr_q;
  logic              terr_q;

  logic              run;
  logic              tick;
  logic              to_hit;
  logic [CH_W-1:0]   lo_ch;
  logic [CH_W-1:0]   nxt_ch;
  logic              nxt_none;

  assign run    = enable && !halt;
  assign tick   = run && (cnt_q == CNT_LAST);
  assign to_hit = TO_EN && (wait_q == WAIT_LAST);

  always_comb begin
    lo_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) lo_ch = CH_W'(i);
    end
  end

  seq_next_ch #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_next (
    .mask_i (mask_q),
    .cur_i  (cur_q),
    .nxt_o  (nxt_ch),
    .none_o (nxt_none)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      mask_q  <= '0;
      cur_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      fdone_q <= 1'b0;
      sch_q   <= '0;
      sdat_q  <= '0;
      ovr_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      fdone_q <= 1'b0;

      if (!run) cnt_q <= '0;
      else if (tick) cnt_q <= '0;
      else cnt_q <= cnt_q + CNT_W'(1);

      // A tick while a frame is still running is dropped, not queued.
      if (tick && state_q != S_IDLE && ovr_q != 8'hFF)
        ovr_q <= ovr_q + 8'd1;

      if (halt) begin
        state_q <= S_IDLE;
        wait_q  <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (tick && |ch_mask) begin
              mask_q  <= ch_mask;
              cur_q   <= lo_ch;
              start_q <= 1'b1;
              state_q <= S_START;
            end
          end
          S_START: begin
            wait_q  <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (adc_done) begin
              sdat_q  <= adc_data;
              sch_q   <= cur_q;
              valid_q <= 1'b1;
              fdone_q <= nxt_none;
              state_q <= S_EMIT;
            end else if (to_hit) begin
              terr_q <= 1'b1;
              if (nxt_none) begin
                fdone_q <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                cur_q   <= nxt_ch;
                start_q <= 1'b1;
                state_q <= S_START;
              end
            end else begin
              wait_q <= wait_q + TW'(1);
            end
          end
          S_EMIT: begin
            if (nxt_none) begin
              state_q <= S_IDLE;
            end else begin
              cur_q   <= nxt_ch;
              start_q <= 1'b1;
              state_q <= S_START;
            end
          end
        endcase
      end
    end
  end

  assign adc_start   = start_q;
  assign adc_ch      = cur_q;
  assign smp_valid   = valid_q;
  assign smp_ch      = sch_q;
  assign smp_data    = sdat_q;
  assign frame_done  = fdone_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun_cnt = ovr_q;
  assign timeout_err = TO_EN & terr_q;

endmodule

// File: tb/tb_eeg_adc_sequencer.sv
// Randomized bench for eeg_adc_sequencer with a frame-level model.
// Expected samples come from mask bits and the data the ADC stub sent.
module tb_eeg_adc_sequencer;

  localparam int NCH = 8;
  localparam int DW  = 24;
  localparam int FD  = 100;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          halt = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic          adc_done = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_start;
  logic [2:0]    adc_ch;
  logic          smp_valid;
  logic [2:0]    smp_ch;
  logic [DW-1:0] smp_data;
  logic          frame_done;
  logic          busy;
  logic [7:0]    overrun_cnt;
  logic          timeout_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int n_fd = 0;
  int start_cyc = 0;
  int last_start_ch = -1;
  int ch_lat [NCH];
  logic [DW-1:0] sent [NCH];
  int q_ch [$];
  logic [DW-1:0] q_dat [$];
  bit q_fd [$];

  eeg_adc_sequencer #(
    .NUM_CH      (NCH),
    .DATA_W      (DW),
    .FRAME_DIV   (FD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .halt        (halt),
    .ch_mask     (ch_mask),
    .adc_start   (adc_start),
    .adc_ch      (adc_ch),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .smp_valid   (smp_valid),
    .smp_ch      (smp_ch),
    .smp_data    (smp_data),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (adc_start === 1'b1) begin
        n_start++;
        start_cyc = cyc;
        last_start_ch = int'(adc_ch);
      end
      if (smp_valid === 1'b1) begin
        q_ch.push_back(int'(smp_ch));
        q_dat.push_back(smp_data);
        q_fd.push_back(frame_done === 1'b1);
      end
      if (frame_done === 1'b1) n_fd++;
    end
  end

  // ADC stub: answers each request after ch_lat cycles; 0 = never.
  initial begin
    int c;
    int l;
    forever begin
      @(posedge clk);
      #1;
      if (adc_start === 1'b1) begin
        c = int'(adc_ch);
        l = ch_lat[c];
        if (l > 0) begin
          repeat (l) @(posedge clk);
          #1;
          adc_data = DW'($urandom());
          sent[c] = adc_data;
          adc_done = 1'b1;
          @(posedge clk);
          #1;
          adc_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    q_ch.delete();
    q_dat.delete();
    q_fd.delete();
  endtask

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < NCH; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic wait_start(input int budget);
    int base;
    int k;
    base = n_start;
    k = 0;
    while (n_start == base && k < budget) begin
      step();
      k++;
    end
    chk("adc_start_seen", n_start != base, 1);
  endtask

  task automatic wait_fd(input int budget);
    int base;
    int k;
    base = n_fd;
    k = 0;
    while (n_fd == base && k < budget) begin
      step();
      k++;
    end
    chk("frame_done_seen", n_fd != base, 1);
  endtask

  task automatic wait_ch(input int ch, input int budget);
    int k;
    k = 0;
    while (last_start_ch != ch && k < budget) begin
      step();
      k++;
    end
    chk("start_on_ch", last_start_ch, ch);
  endtask

  task automatic check_frame(input logic [7:0] m);
    int e [$];
    for (int i = 0; i < NCH; i++) if (m[i]) e.push_back(i);
    chk("n_samples", q_ch.size(), e.size());
    for (int k = 0; k < e.size() && k < q_ch.size(); k++) begin
      chk("smp_ch", q_ch[k], e[k]);
      chk("smp_data", q_dat[k], sent[e[k]]);
      chk("fd_flag", q_fd[k], k == e.size() - 1);
    end
  endtask

  task automatic run_frame(input logic [7:0] m, input logic [7:0] nm);
    int ec;
    clear_q();
    ch_mask = m;
    ec = cyc;
    enable = 1'b1;
    wait_start(FD + 10);
    chk("tick_to_start", start_cyc - ec, FD);
    chk("first_ch", last_start_ch, lowest(m));
    ch_mask = nm;
    enable = 1'b0;
    wait_fd(12 * NCH + 20);
    step();
    step();
    check_frame(m);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] nm;
    int base;
    int el;
    for (int i = 0; i < NCH; i++) ch_lat[i] = 5;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_adc_start", adc_start, 0);
    chk("rst_smp_valid", smp_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_adc_ch", adc_ch, 0);
    chk("rst_smp_ch", smp_ch, 0);
    chk("rst_smp_data", smp_data, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b0;
    step();

    run_frame(8'hFF, 8'hFF);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NCH; i++) ch_lat[i] = $urandom_range(1, 8);
      m  = (f == 0) ? 8'hA4 : 8'($urandom_range(1, 255));
      nm = (f == 0) ? 8'hFF : 8'($urandom());
      run_frame(m, nm);
    end
    for (int i = 0; i < NCH; i++) ch_lat[i] = 5;

    ch_mask = '0;
    base = n_start;
    enable = 1'b1;
    repeat (250) step();
    chk("zero_mask_starts", n_start - base, 0);
    chk("zero_mask_ovr", overrun_cnt, 0);
    chk("zero_mask_busy", busy, 0);
    enable = 1'b0;
    step();

    for (int i = 0; i < NCH; i++) ch_lat[i] = 0;
    ch_mask = 8'h01;
    enable = 1'b1;
    wait_start(FD + 10);
    repeat (150) step();
    el = 150;
    chk("ovr_one", overrun_cnt, (el / FD > 255) ? 255 : el / FD);
    repeat (30000) step();
    el += 30000;
    chk("ovr_sat", overrun_cnt, (el / FD > 255) ? 255 : el / FD);
    halt = 1'b1;
    step();
    enable = 1'b0;
    halt = 1'b0;
    chk("halt_ovr_busy", busy, 0);
    chk("halt_ovr_keep", overrun_cnt, 255);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_clears_ovr", overrun_cnt, 0);
    step();

    for (int i = 0; i < NCH; i++) ch_lat[i] = 5;
    ch_lat[3] = 20;
    clear_q();
    base = n_fd;
    last_start_ch = -1;
    ch_mask = 8'hFF;
    enable = 1'b1;
    wait_start(FD + 10);
    enable = 1'b0;
    wait_ch(3, 200);
    repeat (2) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("halt_idle", busy, 0);
    repeat (30) step();
    chk("halt_n_samples", q_ch.size(), 3);
    for (int k = 0; k < 3 && k < q_ch.size(); k++)
      chk("halt_smp_ch", q_ch[k], k);
    chk("halt_no_fd", n_fd - base, 0);
    chk("halt_late_busy", busy, 0);
    ch_lat[3] = 5;
    run_frame(8'hFF, 8'hFF);

    ch_lat[4] = 0;
    chk("terr_before", timeout_err, 0);
    clear_q();
    last_start_ch = -1;
    ch_mask = 8'hFF;
    enable = 1'b1;
    wait_start(FD + 10);
    enable = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wait_fd(12 * NCH + 2 * TO + 20);
    step();
    chk("terr_set", timeout_err, 1);
    check_frame(8'hEF);
`else
    wait_ch(4, 200);
    base = n_start;
    repeat (40) step();
    chk("wait_busy", busy, 1);
    chk("terr_tied", timeout_err, 0);
    chk("wait_no_start", n_start - base, 0);
    chk("wait_n_samples", q_ch.size(), 4);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("wait_halt_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
